down_counter_timer: RTL and testbench



---
 rtl/down_counter_timer.sv | 94 +++++++++
 tb/tb_down_counter_timer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer: counts from load_val to zero, single-cycle tc pulse on the terminal step.
// Optional feature macro DOWN_COUNTER_TIMER_AUTO_RELOAD_EN: periodic reload instead of one-shot stop in DONE.
module down_counter_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    if (load) begin
      count_d = load_val;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
      reload_d = load_val;
`endif
      // A zero start value is already terminal: report it immediately.
      if (load_val == '0) begin
        state_d = DONE;
        tc_d    = 1'b1;
      end else begin
        state_d = RUN;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (en) begin
            if (count_q == WIDTH'(1)) begin
              tc_d = 1'b1;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
              count_d = reload_q;
`else
              count_d = '0;
              state_d = DONE;
`endif
            end else begin
              count_d = count_q - WIDTH'(1);
            end
          end
        end
        IDLE, DONE: count_d = '0;
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      tc_q    <= 1'b0;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);

endmodule

// File: tb/tb_down_counter_timer.sv
// Self-checking bench for down_counter_timer: directed vector table, corner sequences, random vs. model.
module tb_down_counter_timer;

`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;
  logic       en = 1'b0;
  logic [3:0] count;
  logic       busy, tc, done;

  int n_tests = 0;
  int n_fail  = 0;

  down_counter_timer #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .en(en),
    .count(count), .busy(busy), .tc(tc), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, load;
    logic [3:0] lv;
    logic       en;
    logic [3:0] c;
    logic       b, t, d;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic l, input logic [3:0] lv, input logic e,
                     input logic [3:0] c, input logic b, input logic t, input logic d);
    vec_t v;
    v.rst = r; v.load = l; v.lv = lv; v.en = e;
    v.c = c; v.b = b; v.t = t; v.d = d;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int c, input int b, input int t, input int d);
    check({tag, ".count"}, int'(count), c);
    check({tag, ".busy"},  int'(busy),  b);
    check({tag, ".tc"},    int'(tc),    t);
    check({tag, ".done"},  int'(done),  d);
  endtask

  // Reference model: tracks load value and number of enabled steps since load.
  int m_phase;  // 0 idle, 1 counting, 2 finished
  int m_len, m_steps, m_tc;

  task automatic model_step(input logic r, input logic l, input int lv, input logic e);
    if (r) begin
      m_phase = 0; m_len = 0; m_steps = 0; m_tc = 0;
    end else if (l) begin
      m_len = lv; m_steps = 0;
      m_tc = (lv == 0);
      m_phase = (lv == 0) ? 2 : 1;
    end else if (m_phase == 1 && e) begin
      m_steps++;
      m_tc = (m_steps % m_len == 0);
      if (!AR && m_steps == m_len) m_phase = 2;
    end else begin
      m_tc = 0;
    end
  endtask

  function automatic int model_count();
    return (m_phase == 1) ? (m_len - (m_steps % m_len)) : 0;
  endfunction

  initial begin
    int n, pulses;

    // reset with load asserted
    add(1, 1, 5, 0,  0, 0, 0, 0);
    add(1, 1, 5, 1,  0, 0, 0, 0);
    // countdown from 4
    add(0, 1, 4, 1,  4, 1, 0, 0);
    add(0, 0, 0, 1,  3, 1, 0, 0);
    add(0, 0, 0, 1,  2, 1, 0, 0);
    add(0, 0, 0, 1,  1, 1, 0, 0);
    add(0, 0, 0, 1,  AR ? 4 : 0, AR, 1, !AR);
    add(0, 0, 0, 1,  AR ? 3 : 0, AR, 0, !AR);
    // pause pattern 1,0,0,1,1
    add(0, 1, 3, 1,  3, 1, 0, 0);
    add(0, 0, 0, 1,  2, 1, 0, 0);
    add(0, 0, 0, 0,  2, 1, 0, 0);
    add(0, 0, 0, 0,  2, 1, 0, 0);
    add(0, 0, 0, 1,  1, 1, 0, 0);
    add(0, 0, 0, 1,  AR ? 3 : 0, AR, 1, !AR);
    // zero load: immediate DONE with a single tc
    add(0, 1, 0, 1,  0, 0, 1, 1);
    add(0, 0, 0, 1,  0, 0, 0, 1);
    add(0, 0, 0, 1,  0, 0, 0, 1);
    // reload mid-count at count=2
    add(0, 1, 7, 1,  7, 1, 0, 0);
    for (int i = 6; i >= 2; i--) add(0, 0, 0, 1, 4'(i), 1, 0, 0);
    add(0, 1, 7, 1,  7, 1, 0, 0);
    // load coinciding with the terminal step suppresses tc
    add(0, 1, 1, 1,  1, 1, 0, 0);
    add(0, 1, 5, 1,  5, 1, 0, 0);
    // reset at count=1 drops the pending tc
    add(0, 1, 1, 1,  1, 1, 0, 0);
    add(1, 0, 0, 1,  0, 0, 0, 0);
    add(0, 0, 0, 1,  0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; load = vecs[i].load; load_val = vecs[i].lv; en = vecs[i].en;
      tick();
      check_outs($sformatf("vec%0d", i), vecs[i].c, vecs[i].b, vecs[i].t, vecs[i].d);
    end

    // load_val=15: tc exactly 15 enabled cycles after the load
    rst = 0; load = 1; load_val = 15; en = 1;
    tick();
    load = 0;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (tc) begin n = i; break; end
    end
    check("max_load.cycles_to_tc", n, 15);
    check("max_load.count_at_tc", int'(count), AR ? 15 : 0);

    // 12 enabled cycles after load 3: periodic vs. one-shot pulse count
    load = 1; load_val = 3; en = 1;
    tick();
    load = 0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (tc) pulses++;
    end
    check("period3.pulses", pulses, AR ? 4 : 1);
    check("period3.busy", int'(busy), int'(AR));

    // randomized run against the model
    rst = 1; load = 0; en = 0;
    model_step(1, 0, 0, 0);
    tick();
    check_outs("rnd_rst", model_count(), m_phase == 1, m_tc, m_phase == 2);
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 39) == 0);
      load     = ($urandom_range(0, 9) == 0);
      load_val = 4'($urandom_range(0, 15));
      en       = ($urandom_range(0, 3) != 0);
      model_step(rst, load, int'(load_val), en);
      tick();
      check_outs($sformatf("rnd%0d", i), model_count(), m_phase == 1, m_tc, m_phase == 2);
      n_tests++;
      if (busy && done) begin
        n_fail++;
        $display("FAIL rnd%0d.exclusive: busy=%0d done=%0d required not both 1", i, busy, done);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
